// File: rtl/cellrv32_npu_count_ctrl.sv
// cellrv32_npu_count_ctrl: command sequencer driving the NPU counter; optional watchdog via CELLRV32_NPU_CNT_WATCHDOG_EN
module cellrv32_npu_count_ctrl #(
  parameter int COUNTER_WIDTH = 32,
  parameter int TIMEOUT_SLACK = 4
) (
  input  logic                     clk_i,
  input  logic                     rstn_i,
  input  logic                     cmd_valid_i,
  output logic                     cmd_ready_o,
  input  logic [COUNTER_WIDTH-1:0] cmd_len_i,
  input  logic                     abort_i,
  input  logic                     stall_i,
  output logic                     step_valid_o,
  output logic [COUNTER_WIDTH-1:0] step_idx_o,
  output logic                     done_o,
  output logic                     err_o,
  output logic                     cnt_rstn_o,
  output logic [COUNTER_WIDTH-1:0] cnt_end_val_o,
  output logic                     cnt_load_o,
  output logic                     cnt_enable_o,
  input  logic [COUNTER_WIDTH-1:0] cnt_val_i,
  input  logic                     cnt_event_i
);
`ifdef CELLRV32_NPU_CNT_WATCHDOG_EN
  localparam bit WD = 1'b1;
`else
  localparam bit WD = 1'b0;
`endif
  localparam int W = COUNTER_WIDTH;
  localparam int SLACK = WD ? TIMEOUT_SLACK : 0;
  typedef enum logic [2:0] {IDLE, CLR, LOAD, RUN, DONE} state_t;
  state_t st, nxt;
  logic [W-1:0] len_q;
  logic [W:0] iss;
  logic [W+1:0] lim;
  logic wd_trip, en_nxt, stp_nxt;
  assign cmd_ready_o = st == IDLE;
  // enables stop at len_q+1 (the counter needs one extra to raise its event), or run on through the slack window with the watchdog
  assign lim = {2'b00, len_q} + (W+2)'(SLACK + 1);
  assign wd_trip = WD && st == RUN && {1'b0, iss} == lim && !cnt_event_i;
  // next state plus the enable/step decisions that get registered into the outputs
  always_comb begin
    nxt = st;
    case (st)
      IDLE: nxt = cmd_valid_i ? ((cmd_len_i == '0) ? DONE : CLR) : IDLE;
      CLR: nxt = abort_i ? DONE : LOAD;
      LOAD: nxt = abort_i ? DONE : RUN;
      RUN: nxt = (abort_i || cnt_event_i || wd_trip) ? DONE : RUN;
      default: nxt = IDLE;
    endcase
    en_nxt = nxt == RUN && !stall_i && {1'b0, iss} < lim;
    stp_nxt = en_nxt && iss < {1'b0, len_q};
  end
  // state and registered outputs; the step index adds the enable the counter is consuming at this same edge
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      st <= IDLE;
      len_q <= '0;
      iss <= '0;
      cnt_rstn_o <= 1'b0;
      cnt_end_val_o <= '1;
      cnt_load_o <= 1'b0;
      cnt_enable_o <= 1'b0;
      step_valid_o <= 1'b0;
      step_idx_o <= '0;
      done_o <= 1'b0;
      err_o <= 1'b0;
    end else begin
      st <= nxt;
      if (cmd_ready_o && cmd_valid_i) len_q <= cmd_len_i;
      iss <= nxt == LOAD ? '0 : iss + (W+1)'(en_nxt);
      cnt_rstn_o <= nxt != CLR;
      cnt_load_o <= nxt == LOAD;
      if (nxt == LOAD) cnt_end_val_o <= len_q - 1'b1;
      cnt_enable_o <= en_nxt;
      step_valid_o <= stp_nxt;
      if (stp_nxt) step_idx_o <= cnt_val_i + W'(cnt_enable_o);
      done_o <= nxt == DONE;
      err_o <= nxt == DONE && wd_trip && !abort_i;
    end
  end
endmodule
